// File: rtl/quant_zigzag_buffer.sv
// Ping-pong 8x8 coefficient buffer: raster-order writes, zigzag-order reads,
// reciprocal-multiply quantization with round-half-away-from-zero and saturation.
module quant_zigzag_buffer #(
  parameter int COEF_W  = 16,
  parameter int RECIP_W = 16,
  parameter int OUT_W   = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEF_W-1:0]  in_coeff,
  input  logic [64*RECIP_W-1:0]     recip_table,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_coeff,
  output logic [5:0]                out_pos,
  output logic                      out_last,
  output logic                      block_done
);

  localparam int FRAC   = 16;
  localparam int PROD_W = COEF_W + 1 + RECIP_W + 1;
  localparam int QMAG_W = PROD_W - FRAC;
  localparam logic [PROD_W-1:0] ROUND   = PROD_W'(1) << (FRAC - 1);
  localparam logic [QMAG_W-1:0] POS_LIM = QMAG_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [QMAG_W-1:0] NEG_LIM = QMAG_W'(1 << (OUT_W - 1));
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Raster position visited at each step of the zigzag scan.
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic signed [COEF_W-1:0] bankMem [2][64];

  logic [1:0] full_q, full_d;
  logic       wBank_q, wBank_d;
  logic       rBank_q, rBank_d;
  logic [5:0] wCnt_q, wCnt_d;
  logic [5:0] rCnt_q, rCnt_d;

  logic                    outValid_q, outValid_d;
  logic signed [OUT_W-1:0] outCoeff_q, outCoeff_d;
  logic [5:0]              outPos_q, outPos_d;
  logic                    outLast_q, outLast_d;
  logic                    blockDone_q, blockDone_d;

  logic wrAccept, wrDone, rdLoad, rdDone;
  logic [5:0]               zzPos;
  logic signed [COEF_W-1:0] rdCoef;
  logic [RECIP_W-1:0]       rdRecip;
  logic signed [COEF_W:0]   coefExt;
  logic [COEF_W:0]          coefMag;
  logic [QMAG_W-1:0]        qMag;
  logic signed [OUT_W-1:0]  qCoef;

  assign in_ready = !full_q[wBank_q];
  assign wrAccept = in_valid && in_ready;
  assign wrDone   = wrAccept && (wCnt_q == 6'd63);
  assign rdLoad   = full_q[rBank_q] && (!outValid_q || out_ready);
  assign rdDone   = rdLoad && (rCnt_q == 6'd63);

  assign zzPos   = ZIGZAG[rCnt_q];
  assign rdCoef  = bankMem[rBank_q][zzPos];
  assign rdRecip = recip_table[int'(zzPos)*RECIP_W +: RECIP_W];

  // Magnitude is one bit wider so the most negative coefficient stays exact.
  always_comb begin
    coefExt = (COEF_W+1)'(rdCoef);
    coefMag = coefExt[COEF_W] ? (COEF_W+1)'(-coefExt) : (COEF_W+1)'(coefExt);
    qMag    = QMAG_W'((PROD_W'(coefMag) * PROD_W'(rdRecip) + ROUND) >> FRAC);
    if (coefExt[COEF_W]) begin
      if (qMag > NEG_LIM) qCoef = OUT_MIN;
      else                qCoef = -OUT_W'(qMag);
    end else begin
      if (qMag > POS_LIM) qCoef = OUT_MAX;
      else                qCoef = OUT_W'(qMag);
    end
  end

  // Storage carries no reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wrAccept) bankMem[wBank_q][wCnt_q] <= in_coeff;
  end

  always_comb begin
    full_d  = full_q;
    wBank_d = wBank_q ^ wrDone;
    rBank_d = rBank_q ^ rdDone;
    wCnt_d  = wrAccept ? wCnt_q + 6'd1 : wCnt_q;
    rCnt_d  = rdLoad ? rCnt_q + 6'd1 : rCnt_q;
    if (wrDone) full_d[wBank_q] = 1'b1;
    if (rdDone) full_d[rBank_q] = 1'b0;
  end

  always_comb begin
    outValid_d  = outValid_q;
    outCoeff_d  = outCoeff_q;
    outPos_d    = outPos_q;
    outLast_d   = outLast_q;
    blockDone_d = outValid_q && out_ready && outLast_q;
    if (rdLoad) begin
      outValid_d = 1'b1;
      outCoeff_d = qCoef;
      outPos_d   = zzPos;
      outLast_d  = (rCnt_q == 6'd63);
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= 2'b00;
      wBank_q     <= 1'b0;
      rBank_q     <= 1'b0;
      wCnt_q      <= 6'd0;
      rCnt_q      <= 6'd0;
      outValid_q  <= 1'b0;
      outCoeff_q  <= '0;
      outPos_q    <= 6'd0;
      outLast_q   <= 1'b0;
      blockDone_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wBank_q     <= wBank_d;
      rBank_q     <= rBank_d;
      wCnt_q      <= wCnt_d;
      rCnt_q      <= rCnt_d;
      outValid_q  <= outValid_d;
      outCoeff_q  <= outCoeff_d;
      outPos_q    <= outPos_d;
      outLast_q   <= outLast_d;
      blockDone_q <= blockDone_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_coeff  = outCoeff_q;
  assign out_pos    = outPos_q;
  assign out_last   = outLast_q;
  assign block_done = blockDone_q;

endmodule

// File: tb/tb_quant_zigzag_buffer.sv
// Scoreboard bench for quant_zigzag_buffer: expected zigzag/quantized samples are
// queued as blocks are fed and compared against handshaken outputs.
module tb_quant_zigzag_buffer;

  typedef struct {
    int coeff;
    int pos;
    int last;
  } sample_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [15:0] in_coeff;
  logic [1023:0]     recip_table;
  logic              out_valid;
  logic              out_ready;
  logic signed [8:0] out_coeff;
  logic [5:0]        out_pos;
  logic              out_last;
  logic              block_done;

  sample_t expQ[$];
  sample_t obsQ[$];
  int zzTab [64];
  int blk [64];
  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int acceptCount = 0;
  int lastAcceptCyc = 0;
  int firstValidCyc = -1;
  int doneCount = 0;
  int doneViol = 0;
  int stallViol = 0;
  bit prevStall = 0;
  bit prevHsLast = 0;
  logic signed [8:0] prevCoeff;
  logic [5:0] prevPos;
  logic prevLast;
  bit drvDone;

  quant_zigzag_buffer #(.COEF_W(16), .RECIP_W(16), .OUT_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
    .recip_table(recip_table),
    .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
    .out_pos(out_pos), .out_last(out_last), .block_done(block_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records handshakes, stall stability and block_done placement.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prevStall  = 0;
      prevHsLast = 0;
    end else begin
      if (prevStall && !(out_valid === 1'b1 && out_coeff === prevCoeff &&
                         out_pos === prevPos && out_last === prevLast))
        stallViol++;
      if (block_done !== prevHsLast) doneViol++;
      if (block_done === 1'b1) doneCount++;
      if (out_valid === 1'b1 && firstValidCyc < 0) firstValidCyc = cyc;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        sample_t s;
        s.coeff = int'(out_coeff);
        s.pos   = int'(out_pos);
        s.last  = int'(out_last);
        obsQ.push_back(s);
      end
      prevStall  = (out_valid === 1'b1) && (out_ready === 1'b0);
      prevHsLast = (out_valid === 1'b1) && (out_ready === 1'b1) && (out_last === 1'b1);
      prevCoeff  = out_coeff;
      prevPos    = out_pos;
      prevLast   = out_last;
    end
  end

  function automatic void buildZigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zzTab[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zzTab[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  function automatic int quantModel(int c, int r);
    longint m, qm, q;
    m  = (c < 0) ? -longint'(c) : longint'(c);
    qm = (m * longint'(r) + 64'sd32768) >>> 16;
    q  = (c < 0) ? -qm : qm;
    if (q > 255)  q = 255;
    if (q < -256) q = -256;
    return int'(q);
  endfunction

  function automatic int recipOf(int p);
    logic [15:0] r;
    r = recip_table[p*16 +: 16];
    return int'(r);
  endfunction

  task automatic setRecipAll(input logic [15:0] r);
    for (int i = 0; i < 64; i++) recip_table[i*16 +: 16] = r;
  endtask

  task automatic randomBlock();
    logic signed [15:0] t;
    for (int i = 0; i < 64; i++) begin
      t = 16'($urandom);
      blk[i] = int'(t);
    end
  endtask

  // Drives blk[0..n-1] back to back; a complete block queues its expected output.
  task automatic feedCoeffs(input int n);
    bit acc;
    int waited;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_coeff = 16'(blk[i]);
      waited = 0;
      acc = 0;
      while (!acc) begin
        @(negedge clk);
        acc = (in_ready === 1'b1);
        @(posedge clk);
        #1;
        if (!acc) begin
          waited++;
          if (waited > 1000) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL input_timeout: coeff %0d not accepted, in_ready=%b want 1", i, in_ready);
            in_valid = 1'b0;
            return;
          end
        end
      end
      acceptCount++;
      lastAcceptCyc = cyc;
    end
    in_valid = 1'b0;
    if (n == 64) begin
      for (int k = 0; k < 64; k++) begin
        sample_t s;
        s.pos   = zzTab[k];
        s.coeff = quantModel(blk[zzTab[k]], recipOf(zzTab[k]));
        s.last  = (k == 63) ? 1 : 0;
        expQ.push_back(s);
      end
    end
  endtask

  task automatic waitOutputs(input int n, input int budget);
    for (int c = 0; c < budget && obsQ.size() < n; c++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_coeff = '0;
    out_ready = 1'b1;
    setRecipAll(16'hFFFF);
    #2;
    nChecks++;
    if (out_valid !== 1'b0 || block_done !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_outputs: valid=%b done=%b want 0 0", out_valid, block_done);
    end
    nChecks++;
    if (out_coeff !== 9'd0 || out_pos !== 6'd0 || out_last !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_data: coeff=%0d pos=%0d last=%b want 0 0 0", out_coeff, out_pos, out_last);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
    repeat (10) @(posedge clk);
    #1;
    nChecks++;
    if (obsQ.size() != 0 || out_valid !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL idle_no_output: outputs=%0d valid=%b want 0 0", obsQ.size(), out_valid);
    end
  endtask

  task automatic test_uniform();
    sample_t e, o;
    setRecipAll(16'd4096);
    for (int i = 0; i < 64; i++) blk[i] = 1000;
    firstValidCyc = -1;
    doneCount = 0;
    feedCoeffs(64);
    waitOutputs(64, 300);
    repeat (5) @(posedge clk);
    #1;
    nChecks++;
    if (firstValidCyc != lastAcceptCyc + 1) begin
      nErrors++;
      $display("[TB] FAIL uniform_latency: first valid at cycle %0d want %0d", firstValidCyc, lastAcceptCyc + 1);
    end
    nChecks++;
    if (obsQ.size() != 64) begin
      nErrors++;
      $display("[TB] FAIL uniform_count: got %0d outputs want 64", obsQ.size());
    end
    for (int k = 0; k < 64; k++) begin
      if (obsQ.size() == 0 || expQ.size() == 0) break;
      e = expQ.pop_front();
      o = obsQ.pop_front();
      nChecks++;
      if (o.coeff != 63 || o.coeff != e.coeff || o.pos != e.pos || o.last != e.last) begin
        nErrors++;
        $display("[TB] FAIL uniform[%0d]: got coeff=%0d pos=%0d last=%0d want %0d %0d %0d",
                 k, o.coeff, o.pos, o.last, e.coeff, e.pos, e.last);
      end
    end
    nChecks++;
    if (doneCount != 1) begin
      nErrors++;
      $display("[TB] FAIL uniform_block_done: got %0d pulses want 1", doneCount);
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_ramp();
    sample_t e, o;
    setRecipAll(16'hFFFF);
    for (int i = 0; i < 64; i++) blk[i] = i;
    feedCoeffs(64);
    waitOutputs(64, 300);
    nChecks++;
    if (obsQ.size() != 64) begin
      nErrors++;
      $display("[TB] FAIL ramp_count: got %0d outputs want 64", obsQ.size());
    end
    for (int k = 0; k < 64; k++) begin
      if (obsQ.size() == 0 || expQ.size() == 0) break;
      e = expQ.pop_front();
      o = obsQ.pop_front();
      nChecks++;
      if (o.coeff != zzTab[k] || o.pos != zzTab[k] || o.last != e.last) begin
        nErrors++;
        $display("[TB] FAIL ramp[%0d]: got coeff=%0d pos=%0d last=%0d want %0d %0d %0d",
                 k, o.coeff, o.pos, o.last, zzTab[k], zzTab[k], e.last);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_sign_saturation();
    sample_t e, o;
    int want;
    randomBlock();
    for (int i = 4; i < 64; i++) recip_table[i*16 +: 16] = 16'($urandom_range(1, 65535));
    recip_table[0*16 +: 16] = 16'hFFFF;
    recip_table[1*16 +: 16] = 16'hFFFF;
    recip_table[2*16 +: 16] = 16'h2000;
    recip_table[3*16 +: 16] = 16'h2000;
    blk[0] = -32768;
    blk[1] = 5000;
    blk[2] = -24;
    blk[3] = -20;
    feedCoeffs(64);
    waitOutputs(64, 300);
    nChecks++;
    if (obsQ.size() != 64) begin
      nErrors++;
      $display("[TB] FAIL sign_count: got %0d outputs want 64", obsQ.size());
    end
    for (int k = 0; k < 64; k++) begin
      if (obsQ.size() == 0 || expQ.size() == 0) break;
      e = expQ.pop_front();
      o = obsQ.pop_front();
      nChecks++;
      if (o.coeff != e.coeff || o.pos != e.pos || o.last != e.last) begin
        nErrors++;
        $display("[TB] FAIL sign[%0d]: got coeff=%0d pos=%0d last=%0d want %0d %0d %0d",
                 k, o.coeff, o.pos, o.last, e.coeff, e.pos, e.last);
      end
      if (e.pos < 4) begin
        case (e.pos)
          0: want = -256;
          1: want = 255;
          default: want = -3;
        endcase
        nChecks++;
        if (o.coeff != want) begin
          nErrors++;
          $display("[TB] FAIL sign_boundary pos %0d: got %0d want %0d", e.pos, o.coeff, want);
        end
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_back_to_back();
    sample_t e, o;
    int base;
    logic signed [8:0] held;
    setRecipAll(16'h1800);
    out_ready = 1'b0;
    base = acceptCount;
    drvDone = 0;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          randomBlock();
          feedCoeffs(64);
        end
        drvDone = 1;
      end
    join_none
    for (int c = 0; c < 500 && acceptCount - base < 128; c++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    nChecks++;
    if (acceptCount - base != 128 || in_ready !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL b2b_full_stall: accepts=%0d in_ready=%b want 128 0", acceptCount - base, in_ready);
    end
    held = out_coeff;
    repeat (5) @(posedge clk);
    #1;
    nChecks++;
    if (out_valid !== 1'b1 || out_coeff !== held) begin
      nErrors++;
      $display("[TB] FAIL b2b_hold: valid=%b coeff=%0d want 1 %0d", out_valid, out_coeff, held);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 1000 && !drvDone; c++) @(posedge clk);
    waitOutputs(192, 600);
    repeat (5) @(posedge clk);
    #1;
    nChecks++;
    if (obsQ.size() != 192 || !drvDone) begin
      nErrors++;
      $display("[TB] FAIL b2b_count: got %0d outputs (driver done %0d) want 192", obsQ.size(), drvDone);
    end
    for (int k = 0; k < 192; k++) begin
      if (obsQ.size() == 0 || expQ.size() == 0) break;
      e = expQ.pop_front();
      o = obsQ.pop_front();
      nChecks++;
      if (o.coeff != e.coeff || o.pos != e.pos || o.last != e.last) begin
        nErrors++;
        $display("[TB] FAIL b2b[%0d]: got coeff=%0d pos=%0d last=%0d want %0d %0d %0d",
                 k, o.coeff, o.pos, o.last, e.coeff, e.pos, e.last);
      end
    end
    nChecks++;
    if (stallViol != 0 || doneViol != 0) begin
      nErrors++;
      $display("[TB] FAIL stall_and_done_timing: stall violations=%0d done violations=%0d want 0 0", stallViol, doneViol);
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_reset_midstream();
    sample_t e, o;
    setRecipAll(16'h0C00);
    out_ready = 1'b0;
    randomBlock();
    feedCoeffs(64);
    randomBlock();
    feedCoeffs(30);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (out_valid !== 1'b0 || out_coeff !== 9'd0 || out_pos !== 6'd0 ||
        out_last !== 1'b0 || block_done !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL midreset_outputs: valid=%b coeff=%0d pos=%0d last=%b done=%b want all 0",
               out_valid, out_coeff, out_pos, out_last, block_done);
    end
    expQ.delete();
    obsQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    nChecks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL midreset_release: in_ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    doneCount = 0;
    out_ready = 1'b1;
    randomBlock();
    feedCoeffs(64);
    waitOutputs(64, 300);
    repeat (30) @(posedge clk);
    #1;
    nChecks++;
    if (obsQ.size() != 64 || doneCount != 1) begin
      nErrors++;
      $display("[TB] FAIL midreset_count: got %0d outputs %0d done pulses want 64 1", obsQ.size(), doneCount);
    end
    for (int k = 0; k < 64; k++) begin
      if (obsQ.size() == 0 || expQ.size() == 0) break;
      e = expQ.pop_front();
      o = obsQ.pop_front();
      nChecks++;
      if (o.coeff != e.coeff || o.pos != e.pos || o.last != e.last) begin
        nErrors++;
        $display("[TB] FAIL midreset[%0d]: got coeff=%0d pos=%0d last=%0d want %0d %0d %0d",
                 k, o.coeff, o.pos, o.last, e.coeff, e.pos, e.last);
      end
    end
  endtask

  initial begin
    buildZigzag();
    test_reset();
    test_uniform();
    test_ramp();
    test_sign_saturation();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/quant_zigzag_buffer.md
Name: quant_zigzag_buffer

Overview:
Compressor-side stage that produces the signed 9-bit quantized coefficient stream the decompressor consumes. It accepts 8x8 blocks of DCT coefficients in raster order over a valid/ready interface and stores them in a ping-pong buffer. Each stored coefficient is quantized by reciprocal multiply with round-half-away-from-zero, then saturated. Quantized values are emitted in JPEG zigzag order over a second valid/ready interface. It sits between the forward DCT and the entropy/packing stage of compressor_top.

Parameters:
COEF_W, 16, signed DCT coefficient input width
RECIP_W, 16, unsigned reciprocal quantizer entry width (value = round(2^16 / Qstep))
OUT_W, 9, signed quantized output width; saturation range [-256, 255]

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_coeff valid
in_ready  output  1  block accepts a coefficient this cycle
in_coeff  input  COEF_W  signed coefficient, raster order, 64 per block
recip_table  input  64*RECIP_W  reciprocals, entry r at bits [r*RECIP_W +: RECIP_W], raster-indexed; held stable while any block is buffered
out_valid  output  1  out_coeff valid
out_ready  input  1  downstream accepts
out_coeff  output  OUT_W  signed quantized coefficient, zigzag order
out_pos  output  6  raster position of out_coeff
out_last  output  1  high with the 64th output of a block
block_done  output  1  one-cycle pulse after the out_last handshake

Behaviour:
- Reset (async assert, sync release): both banks empty, write/read counters 0, write/read bank select 0. out_valid=0, out_coeff=0, out_pos=0, out_last=0, block_done=0. in_ready=1 from the first cycle after release.
- Write side: in_ready = !full[wbank]. On accept (in_valid&in_ready), store at bank[wbank][wcnt] and increment wcnt. On the 64th accept: full[wbank] set, wbank toggles, wcnt wraps to 0.
- Read side: rcnt indexes the zigzag ROM (0,1,8,16,9,2,3,10,17,24,...,55,62,63). The output register loads when full[rbank] && (!out_valid || out_ready). It loads quantized bank[rbank][zz[rcnt]], out_pos=zz[rcnt], out_last=(rcnt==63). rcnt then increments. After loading rcnt==63: full[rbank] cleared, rbank toggles, rcnt wraps to 0.
- When the output register cannot load and out_ready is high, out_valid drops to 0. Otherwise out_valid and the output data hold stable while out_ready is low.
- Latency: 64th input accepted at edge k -> first out_valid high after edge k+1. Sustained throughput is 1 coefficient/cycle in and out.
- Quantization, combinational at read:
  - mag = |coef|, formed at COEF_W+1 bits so that -32768 is handled.
  - qmag = (mag*recip + 2^15) >> 16.
  - q = coef<0 ? -qmag : qmag.
  - Saturate q to [-256, 255].
- Simultaneous events:
  - A write completing one bank and a read completing the other in the same cycle both take effect.
  - A bank freed by the final read is writable the next cycle (in_ready rises after that edge).
- Both banks full: in_ready=0 until a read drain completes.
- block_done: registered. It is high in the cycle after the handshake where out_last=1.
- Reset mid-operation: all buffered data is discarded and outputs return to reset values immediately.

Test Plan:
1. Reset: rst_n low mid-cycle -> out_valid=0, block_done=0 immediately. in_ready=1 after release. No outputs without input.
2. 64 coeffs all 1000, all recip 4096 (Qstep 16), out_ready=1 -> 64 outputs of 63 (62.5 rounds away from zero). out_last only on the 64th. block_done pulses once. First out_valid 1 cycle after the 64th accept.
3. Raster ramp coeff[i]=i, recip 0xFFFF -> outputs 0,1,8,16,9,2,3,10,17,24,... ending 62,63, with out_pos equal to out_coeff.
4. Sign/saturation, recip 0xFFFF unless noted:
   - coeff -32768 -> -256.
   - coeff 5000 -> 255.
   - coeff -24 with recip 0x2000 -> -3.
   - coeff -20 with recip 0x2000 (-2.5) -> -3.
5. Backpressure: stream 3 blocks continuously with out_ready=0 -> in_ready falls after exactly 128 accepts. Then out_ready=1 -> 192 outputs in correct per-block zigzag order, no loss or duplication. out_coeff holds stable while stalled.
6. Reset after 30 coeffs of block 1 with block 0 partly drained -> outputs clear. The next full block produces exactly 64 outputs with correct values and no residual data.
